icache_uncache_rd: RTL and testbench
====================================

# icache_uncache_rd

Uncached instruction-fetch read engine. It sits inside the I-cache on the uncached path and is the responder for pre-IF fetch requests whose ITLB translation marks them uncached. It accepts one physical fetch address, issues a single-beat AXI read on the uncache bus, and returns the 32-bit instruction word to the IF stage. It holds the result until the pipeline is no longer stalled.

## Interface
- `AXI_ID`, default 4'h1: ARID driven on every request; RID is ignored.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: uncached fetch request present (pre-IF PC valid and not cached).
- `req_paddr` in 32: physical fetch address; bits [1:0] are ignored and ARADDR[1:0] is forced to 0.
- `flush` in 1: pipeline redirect; discards any outstanding or held result.
- `cpu_stall` in 1: IF cannot consume; the held result must persist.
- `busy` out 1: fetch in flight; the pipeline must stall pre-IF.
- `resp_valid` out 1: `resp_rdata` is valid.
- `resp_rdata` out 32: fetched instruction.
- `resp_err` out 1: RRESP was not OKAY; qualified by `resp_valid`.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1: AXI read address channel.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI read data channel.

## Operation
- FSM states: IDLE, AR, R, DONE.
- IDLE: on `req_valid && !flush`, latch `req_paddr` into `addr_q`, clear `discard_q`, and go to AR.
- AR: `arvalid=1` and `araddr={addr_q[31:2],2'b00}`. On `arready`, go to R. `arvalid` must stay asserted until the handshake completes; `flush` never drops it.
- R: `rready=1`. On `rvalid && rlast`, capture `rdata` and the `rresp!=2'b00` flag. If `discard_q` is set, go to IDLE; otherwise go to DONE.
- DONE: `resp_valid=1`. If `flush`, go to IDLE. Else if `!cpu_stall`, go to IDLE, with the word consumed that cycle. Else stay in DONE.
- A `flush` while in AR or R sets `discard_q`. The transaction completes and its data is dropped.
- `busy = (IDLE && req_valid && !flush) || AR || R`.
- Constant AR fields: `arlen=0`, `arsize=3'b010`, `arburst=2'b01`, `arid=AXI_ID`.
- An `rvalid` without `rlast` in state R is treated as the last beat.
- A new request is never accepted in DONE. The next request is sampled in IDLE on the following cycle.

## Timing
- Reset values: state IDLE, `arvalid=0`, `rready=0`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `busy=0` (with `req_valid=0`), `araddr=0`, `discard_q=0`.
- Minimum latency: request in cycle 0, `arvalid` in cycle 1. With `arready` in cycle 1 and `rvalid` in cycle 2, `resp_valid` rises in cycle 3.
- `resp_rdata` and `resp_err` are registered. They are stable for as long as `resp_valid` is high.
- Reset mid-transaction: the FSM returns to IDLE immediately and the AXI valid and ready outputs drop. The slave shares `resetn`.
- `flush` and `cpu_stall` asserted together in DONE: flush wins and the FSM goes to IDLE.

## Configuration
- `UNCACHE_IHIT_BUF_EN` defined:
  - A one-entry buffer holds {valid, paddr[31:2], word, err}. It is written on every completed non-discarded read.
  - A request in IDLE whose `paddr[31:2]` matches a valid entry skips AR and R. It goes directly to DONE with the buffered word, and `busy` stays 0.
  - `flush` does not clear the buffer.
- Undefined: no buffer exists, and every request issues an AXI read.

## Structure
- Shared package `uncache_pkg` holds:
  - the state enum `uc_state_t` (IDLE/AR/R/DONE);
  - AXI constants `AXI_BURST_INCR=2'b01`, `AXI_SIZE_4B=3'b010`, `AXI_RESP_OKAY=2'b00`.
- Optional sub-module `uncache_ibuf`, instantiated only under the macro, provides the hit buffer with a lookup port and a fill port.

## Test plan
- Single fetch, `req_paddr=32'hBFC0_0003`, `arready` and `rvalid` immediate → `araddr=32'hBFC0_0000` in cycle 1; `resp_valid=1` in cycle 3 with `resp_rdata` equal to the slave's `rdata` (e.g. 32'h2408_0001); `resp_err=0`.
- `arready` delayed 5 cycles → `arvalid` and `araddr` remain stable for 5 cycles and `busy` stays 1 throughout; `resp_valid` rises 2 cycles after the handshake.
- `flush` pulsed while in R → the transaction completes, `resp_valid` never rises, the FSM returns to IDLE, and the next request issues a new AR.
- `cpu_stall=1` for 4 cycles in DONE → `resp_valid` and `resp_rdata` are held for 4 cycles, then the FSM goes to IDLE one cycle after the stall drops.
- Slave returns `rresp=2'b10` → `resp_valid=1` with `resp_err=1`.
- With `UNCACHE_IHIT_BUF_EN`, the same address is requested twice → the second request produces no `arvalid` and gives `resp_valid` one cycle after the request with the identical word.

Source files
------------

// File: rtl/uncache_pkg.sv
// Shared types and AXI constants for the uncached instruction-fetch path.
package uncache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        DONE = 2'd3
    } uc_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/uncache_ibuf.sv
// One-entry hit buffer for the uncached fetch path. It remembers the last
// completed uncached word so that a repeat fetch of the same word-aligned
// address can be answered without an AXI read. Only instantiated when
// UNCACHE_IHIT_BUF_EN is defined.
module uncache_ibuf (
    input  logic        clk,
    input  logic        resetn,
    input  logic [29:0] lkup_tag_i,
    output logic        lkup_hit_o,
    output logic [31:0] lkup_word_o,
    output logic        lkup_err_o,
    input  logic        fill_en_i,
    input  logic [29:0] fill_tag_i,
    input  logic [31:0] fill_word_i,
    input  logic        fill_err_i
);

    logic        valid_q;
    logic [29:0] tag_q;
    logic [31:0] word_q;
    logic        err_q;

    // Entry storage: overwritten by every fill, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else if (fill_en_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
            word_q  <= fill_word_i;
            err_q   <= fill_err_i;
        end
    end

    assign lkup_hit_o  = valid_q && (tag_q == lkup_tag_i);
    assign lkup_word_o = word_q;
    assign lkup_err_o  = err_q;

endmodule

// File: rtl/icache_uncache_rd.sv
// Uncached instruction-fetch read engine: one single-beat AXI read per
// fetch, result held in DONE until the IF stage consumes it or a flush.
// Optional feature: UNCACHE_IHIT_BUF_EN adds a one-entry hit buffer.
//
// state | meaning
// IDLE  | waiting for an uncached fetch request
// AR    | driving the read address until ARREADY
// R     | waiting for the read data beat
// DONE  | presenting the fetched word to IF
module icache_uncache_rd
    import uncache_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'h1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [31:0] req_paddr,
    input  logic        flush,
    input  logic        cpu_stall,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    uc_state_t   state_q, state_d;
    logic [29:0] addr_q;
    logic        discard_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        r_done;
    logic        drop;
    logic        hit;
    logic [31:0] hit_word;
    logic        hit_err;

    // Every R-state beat is final, so RLAST and RID carry no information here.
    logic        unused_inputs;
    assign unused_inputs = ^{rid, rlast, req_paddr[1:0]};

    assign accept = (state_q == IDLE) && req_valid && !flush;
    assign r_done = (state_q == R) && rvalid;
    // A flush arriving on the data beat itself also kills the result.
    assign drop   = discard_q || flush;

`ifdef UNCACHE_IHIT_BUF_EN
    uncache_ibuf u_ibuf (
        .clk         (clk),
        .resetn      (resetn),
        .lkup_tag_i  (req_paddr[31:2]),
        .lkup_hit_o  (hit),
        .lkup_word_o (hit_word),
        .lkup_err_o  (hit_err),
        .fill_en_i   (r_done && !drop),
        .fill_tag_i  (addr_q),
        .fill_word_i (rdata),
        .fill_err_i  (rresp != AXI_RESP_OKAY)
    );
`else
    assign hit      = 1'b0;
    assign hit_word = '0;
    assign hit_err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = hit ? DONE : AR;
            AR:      if (arready) state_d = R;
            R:       if (rvalid) state_d = drop ? IDLE : DONE;
            DONE:    if (flush || !cpu_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address latch, discard flag and registered response word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= '0;
            discard_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= req_paddr[31:2];
                discard_q <= 1'b0;
                if (hit) begin
                    rdata_q <= hit_word;
                    err_q   <= hit_err;
                end
            end else if (((state_q == AR) || (state_q == R)) && flush) begin
                discard_q <= 1'b1;
            end
            if (r_done && !drop) begin
                rdata_q <= rdata;
                err_q   <= (rresp != AXI_RESP_OKAY);
            end
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        arvalid    = (state_q == AR);
        rready     = (state_q == R);
        resp_valid = (state_q == DONE);
        busy       = (accept && !hit) || (state_q == AR) || (state_q == R);
    end

    assign araddr     = {addr_q, 2'b00};
    assign arid       = AXI_ID;
    assign arlen      = 8'd0;
    assign arsize     = AXI_SIZE_4B;
    assign arburst    = AXI_BURST_INCR;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_icache_uncache_rd.sv
// Self-checking bench for icache_uncache_rd; honours UNCACHE_IHIT_BUF_EN.
module tb_icache_uncache_rd;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_paddr = '0;
    logic        flush = 1'b0;
    logic        cpu_stall = 1'b0;
    logic        busy, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;

    int checks = 0;
    int errors = 0;

`ifdef UNCACHE_IHIT_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    // Reference model of the hit buffer contents.
    bit          bm_valid = 1'b0;
    logic [29:0] bm_tag = '0;
    logic [31:0] bm_word = '0;
    bit          bm_err = 1'b0;

    // Observations gathered by run_fetch.
    bit          o_busy0, o_err, o_ar_unstable, o_busy_bad, o_resp_unstable, o_timeout, o_const_bad;
    int          o_ar_cycles, o_hs_cyc, o_resp_cyc, o_hold;
    logic [31:0] o_araddr, o_data;

    always #5 clk = ~clk;

    icache_uncache_rd #(.AXI_ID(4'h1)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_paddr(req_paddr),
        .flush(flush), .cpu_stall(cpu_stall), .busy(busy), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    function automatic bit exp_hit(input logic [31:0] a);
        return BUF_EN && bm_valid && (bm_tag == a[31:2]);
    endfunction

    function automatic void model_fill(input logic [31:0] a, input logic [31:0] w, input logic [1:0] r);
        bm_valid = 1'b1;
        bm_tag   = a[31:2];
        bm_word  = w;
        bm_err   = (r != 2'b00);
    endfunction

    // Issue one fetch and play the AXI slave; called at #1 after a rising edge.
    task automatic run_fetch(input logic [31:0] addr, input int ar_dly, input int r_dly,
                             input logic [31:0] wdata, input logic [1:0] wresp,
                             input int stall_n, input bit flush_r, input int flush_d);
        int cyc, ar_w, r_w, r_hs;
        bit rsp_seen;
        o_ar_cycles = 0; o_hs_cyc = -1; o_resp_cyc = -1; o_hold = 0;
        o_ar_unstable = 0; o_busy_bad = 0; o_resp_unstable = 0; o_timeout = 0; o_const_bad = 0;
        o_araddr = '0; o_data = '0; o_err = 0;
        req_valid = 1'b1; req_paddr = addr; cpu_stall = (stall_n > 0);
        #1 o_busy0 = busy;
        @(posedge clk); #1;
        req_valid = 1'b0; req_paddr = $urandom;
        cyc = 1; ar_w = 0; r_w = 0; r_hs = -1; rsp_seen = 0;
        forever begin
            flush = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            if (arvalid) begin
                if (o_ar_cycles == 0) o_araddr = araddr;
                else if (araddr !== o_araddr) o_ar_unstable = 1;
                if (!busy) o_busy_bad = 1;
                if (arlen !== 8'd0 || arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'h1) o_const_bad = 1;
                o_ar_cycles++;
                if (ar_w == ar_dly) begin arready = 1'b1; o_hs_cyc = cyc; end
                ar_w++;
            end
            if (rready) begin
                if (!busy) o_busy_bad = 1;
                if (flush_r && r_w == 0) flush = 1'b1;
                if (r_w == r_dly) begin
                    rvalid = 1'b1; rdata = wdata; rresp = wresp;
                    rlast = 1'($urandom_range(0, 1)); rid = 4'($urandom); r_hs = cyc;
                end
                r_w++;
            end
            if (resp_valid) begin
                if (!rsp_seen) begin
                    rsp_seen = 1; o_resp_cyc = cyc; o_data = resp_rdata; o_err = resp_err;
                end else if (resp_rdata !== o_data || resp_err !== o_err) begin
                    o_resp_unstable = 1;
                end
                o_hold++;
                cpu_stall = (o_hold <= stall_n);
                if (flush_d > 0 && o_hold == flush_d) flush = 1'b1;
            end
            if (rsp_seen && !resp_valid) break;
            if (!rsp_seen && r_hs >= 0 && cyc >= r_hs + 3) break;
            if (cyc >= 80) begin o_timeout = 1; break; end
            @(posedge clk); #1;
            cyc++;
        end
        flush = 1'b0; arready = 1'b0; rvalid = 1'b0; cpu_stall = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b want 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready got %b want 0", rready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr got %h want 0", araddr); end
        @(posedge clk); #1;
        resetn = 1'b1;
        bm_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        run_fetch(32'hBFC0_0003, 0, 0, 32'h2408_0001, 2'b00, 0, 0, 0);
        checks++; if (o_busy0 !== 1'b1) begin errors++; $display("FAIL single_busy0 got %b want 1", o_busy0); end
        checks++; if (o_araddr !== 32'hBFC0_0000) begin errors++; $display("FAIL single_araddr got %h want bfc00000", o_araddr); end
        checks++; if (o_hs_cyc !== 1) begin errors++; $display("FAIL single_ar_cycle got %0d want 1", o_hs_cyc); end
        checks++; if (o_resp_cyc !== 3) begin errors++; $display("FAIL single_resp_cycle got %0d want 3", o_resp_cyc); end
        checks++; if (o_data !== 32'h2408_0001) begin errors++; $display("FAIL single_rdata got %h want 24080001", o_data); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", o_err); end
        checks++; if (o_const_bad !== 1'b0) begin errors++; $display("FAIL single_ar_fields got bad=%b want 0", o_const_bad); end
        checks++; if (o_hold !== 1) begin errors++; $display("FAIL single_hold got %0d want 1", o_hold); end
        model_fill(32'hBFC0_0003, 32'h2408_0001, 2'b00);
    endtask

    task automatic test_ar_delay;
        run_fetch(32'h8000_1004, 5, 0, 32'hCAFE_0001, 2'b00, 0, 0, 0);
        checks++; if (o_ar_cycles !== 6) begin errors++; $display("FAIL ardly_arvalid_cycles got %0d want 6", o_ar_cycles); end
        checks++; if (o_ar_unstable !== 1'b0) begin errors++; $display("FAIL ardly_araddr_stable got unstable=%b want 0", o_ar_unstable); end
        checks++; if (o_busy_bad !== 1'b0) begin errors++; $display("FAIL ardly_busy got drop=%b want 0", o_busy_bad); end
        checks++; if (o_resp_cyc !== o_hs_cyc + 2 || o_hs_cyc !== 6) begin errors++; $display("FAIL ardly_latency got hs=%0d resp=%0d want hs=6 resp=8", o_hs_cyc, o_resp_cyc); end
        checks++; if (o_data !== 32'hCAFE_0001) begin errors++; $display("FAIL ardly_rdata got %h want cafe0001", o_data); end
        model_fill(32'h8000_1004, 32'hCAFE_0001, 2'b00);
    endtask

    task automatic test_flush_in_r;
        run_fetch(32'h8000_2008, 0, 2, 32'hDEAD_0002, 2'b00, 0, 1, 0);
        checks++; if (o_resp_cyc !== -1 || o_timeout) begin errors++; $display("FAIL flushr_no_resp got resp_cycle=%0d timeout=%b want -1/0", o_resp_cyc, o_timeout); end
        checks++; if (busy !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL flushr_idle got busy=%b arvalid=%b rready=%b want 0", busy, arvalid, rready); end
        run_fetch(32'h8000_2008, 1, 0, 32'hBEEF_0003, 2'b00, 0, 0, 0);
        checks++; if (o_ar_cycles !== 2) begin errors++; $display("FAIL flushr_new_ar got %0d want 2", o_ar_cycles); end
        checks++; if (o_data !== 32'hBEEF_0003 || o_resp_cyc !== 4) begin errors++; $display("FAIL flushr_next_data got %h at %0d want beef0003 at 4", o_data, o_resp_cyc); end
        model_fill(32'h8000_2008, 32'hBEEF_0003, 2'b00);
    endtask

    task automatic test_stall;
        run_fetch(32'h8000_300C, 0, 1, 32'h1234_5678, 2'b00, 4, 0, 0);
        checks++; if (o_hold !== 5) begin errors++; $display("FAIL stall_hold got %0d want 5", o_hold); end
        checks++; if (o_resp_unstable !== 1'b0) begin errors++; $display("FAIL stall_stable got unstable=%b want 0", o_resp_unstable); end
        checks++; if (o_data !== 32'h1234_5678) begin errors++; $display("FAIL stall_rdata got %h want 12345678", o_data); end
        model_fill(32'h8000_300C, 32'h1234_5678, 2'b00);
    endtask

    task automatic test_flush_done;
        run_fetch(32'h8000_3800, 0, 0, 32'h0BAD_F00D, 2'b00, 6, 0, 2);
        checks++; if (o_hold !== 2) begin errors++; $display("FAIL flushdone_hold got %0d want 2", o_hold); end
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL flushdone_idle got busy=%b resp_valid=%b want 0", busy, resp_valid); end
        model_fill(32'h8000_3800, 32'h0BAD_F00D, 2'b00);
    endtask

    task automatic test_err;
        run_fetch(32'h8000_4010, 0, 0, 32'h5555_AAAA, 2'b10, 0, 0, 0);
        checks++; if (o_err !== 1'b1 || o_resp_cyc !== 3) begin errors++; $display("FAIL err_flag got err=%b at %0d want 1 at 3", o_err, o_resp_cyc); end
        checks++; if (o_data !== 32'h5555_AAAA) begin errors++; $display("FAIL err_rdata got %h want 5555aaaa", o_data); end
        model_fill(32'h8000_4010, 32'h5555_AAAA, 2'b10);
    endtask

    task automatic test_buffer;
        bit h;
        h = exp_hit(32'h8000_4012);
        run_fetch(32'h8000_4012, 3, 3, 32'h7777_0000, 2'b00, 0, 0, 0);
        checks++; if (o_ar_cycles !== (h ? 0 : 4)) begin errors++; $display("FAIL buf_ar_cycles got %0d want %0d", o_ar_cycles, h ? 0 : 4); end
        checks++; if (o_resp_cyc !== (h ? 1 : 9)) begin errors++; $display("FAIL buf_latency got %0d want %0d", o_resp_cyc, h ? 1 : 9); end
        checks++; if (o_data !== (h ? 32'h5555_AAAA : 32'h7777_0000) || o_err !== h) begin errors++; $display("FAIL buf_word got %h/%b want %h/%b", o_data, o_err, h ? 32'h5555_AAAA : 32'h7777_0000, h); end
        checks++; if (o_busy0 !== !h) begin errors++; $display("FAIL buf_busy got %b want %b", o_busy0, !h); end
        if (!h) model_fill(32'h8000_4012, 32'h7777_0000, 2'b00);
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_paddr = 32'h8000_5000;
        @(posedge clk); #1;
        req_valid = 1'b0; arready = 1'b1;
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rstmid_arvalid got %b want 1", arvalid); end
        @(posedge clk); #1;
        arready = 1'b0;
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rstmid_rready got %b want 1", rready); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_drop got arvalid=%b rready=%b busy=%b resp_valid=%b want 0", arvalid, rready, busy, resp_valid); end
        checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL rstmid_araddr got %h want 0", araddr); end
        @(posedge clk); #1;
        resetn = 1'b1;
        bm_valid = 1'b0;
        @(posedge clk); #1;
        run_fetch(32'h8000_5000, 0, 0, 32'hA5A5_5A5A, 2'b00, 0, 0, 0);
        checks++; if (o_resp_cyc !== 3 || o_data !== 32'hA5A5_5A5A || o_ar_cycles !== 1) begin errors++; $display("FAIL rstmid_after got resp=%0d data=%h ar=%0d want 3/a5a55a5a/1", o_resp_cyc, o_data, o_ar_cycles); end
        model_fill(32'h8000_5000, 32'hA5A5_5A5A, 2'b00);
    endtask

    task automatic test_random;
        logic [31:0] addr, wdata, exp_data;
        logic [1:0]  wresp;
        int ar_d, r_d, st, exp_resp, exp_ar;
        bit fl, h, exp_err;
        for (int i = 0; i < 40; i++) begin
            addr  = {28'h8000_F00, 2'($urandom_range(0, 3)), 2'($urandom)};
            ar_d  = $urandom_range(0, 3);
            r_d   = $urandom_range(0, 3);
            wdata = $urandom;
            wresp = 2'($urandom);
            st    = $urandom_range(0, 2);
            fl    = (r_d > 0) && ($urandom_range(0, 5) == 0);
            h     = exp_hit(addr);
            exp_ar   = h ? 0 : ar_d + 1;
            exp_resp = h ? 1 : (fl ? -1 : 3 + ar_d + r_d);
            exp_data = h ? bm_word : wdata;
            exp_err  = h ? bm_err : (wresp != 2'b00);
            run_fetch(addr, ar_d, r_d, wdata, wresp, st, fl, 0);
            checks++; if (o_timeout || o_ar_unstable || o_busy_bad || o_const_bad) begin errors++; $display("FAIL rnd%0d_protocol got timeout=%b unstable=%b busy_drop=%b fields=%b want 0", i, o_timeout, o_ar_unstable, o_busy_bad, o_const_bad); end
            checks++; if (o_ar_cycles !== exp_ar) begin errors++; $display("FAIL rnd%0d_ar_cycles got %0d want %0d", i, o_ar_cycles, exp_ar); end
            checks++; if (!h && o_araddr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL rnd%0d_araddr got %h want %h", i, o_araddr, {addr[31:2], 2'b00}); end
            checks++; if (o_resp_cyc !== exp_resp) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, o_resp_cyc, exp_resp); end
            if (exp_resp >= 0) begin
                checks++; if (o_data !== exp_data || o_err !== exp_err) begin errors++; $display("FAIL rnd%0d_word got %h/%b want %h/%b", i, o_data, o_err, exp_data, exp_err); end
                checks++; if (o_hold !== st + 1 || o_resp_unstable) begin errors++; $display("FAIL rnd%0d_hold got %0d unstable=%b want %0d", i, o_hold, o_resp_unstable, st + 1); end
            end
            checks++; if (o_busy0 !== !h) begin errors++; $display("FAIL rnd%0d_busy0 got %b want %b", i, o_busy0, !h); end
            if (!h && !fl) model_fill(addr, wdata, wresp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_ar_delay();
        test_flush_in_r();
        test_stall();
        test_flush_done();
        test_err();
        test_buffer();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
